// File: rtl/mcu_sequencer_if.sv
// Block-stream bus between the IDCT source, mcu_sequencer and supersample_buffer_top.
// master is the sequencer's view; slave is the environment's view.
interface mcu_sequencer_if;
    logic                 in_valid;
    logic                 in_ready;
    logic [7:0][7:0][7:0] in_block;
    logic                 buf_valid;
    logic [1:0]           buf_ch;
    logic [7:0][7:0][7:0] buf_block;
    logic                 buf_mcu_done;

    modport master (
        input  in_valid, in_block, buf_mcu_done,
        output in_ready, buf_valid, buf_ch, buf_block
    );

    modport slave (
        output in_valid, in_block, buf_mcu_done,
        input  in_ready, buf_valid, buf_ch, buf_block
    );
endinterface

// File: rtl/mcu_sequencer.sv
// Tags an untagged IDCT block stream with 4:2:0 channel order (Y0..Y3, Cb, Cr) per MCU and
// limits the number of MCUs in flight in supersample_buffer_top.
module mcu_sequencer #(
    parameter int unsigned MAX_OUT = 2,
    parameter int unsigned CNT_W   = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [CNT_W-1:0] num_mcu,
    mcu_sequencer_if.master  bus,
    output logic             busy,
    output logic             frame_done,
    output logic [CNT_W-1:0] mcu_idx,
    output logic             err
);
    localparam int unsigned     OutW   = $clog2(MAX_OUT + 1);
    localparam logic [OutW-1:0] OutMax = OutW'(MAX_OUT);

    typedef enum logic [2:0] {
        StIdle, StY0, StY1, StY2, StY3, StCb, StCr, StDrain
    } state_e;

    state_e               state_q, state_d;
    logic [OutW-1:0]      out_q, out_d;
    logic [CNT_W-1:0]     idx_q, idx_d;
    logic [CNT_W-1:0]     num_q, num_d;
    logic                 err_q, err_d;
    logic                 buf_valid_q;
    logic [1:0]           buf_ch_q;
    logic [7:0][7:0][7:0] buf_block_q;

    logic       in_slot;
    logic [1:0] slot_ch;
    logic       in_ready;
    logic       hs;
    logic       cr_hs;
    logic       done;
    logic       last_mcu;

    always_comb begin
        in_slot = 1'b0;
        slot_ch = 2'd0;
        unique case (state_q)
            StY0, StY1, StY2, StY3: begin
                in_slot = 1'b1;
                slot_ch = 2'd0;
            end
            StCb: begin
                in_slot = 1'b1;
                slot_ch = 2'd1;
            end
            StCr: begin
                in_slot = 1'b1;
                slot_ch = 2'd2;
            end
            default: ;
        endcase
    end

    // A new MCU may not begin while the buffer already holds MAX_OUT unfinished MCUs.
    assign in_ready = in_slot && !((state_q == StY0) && (out_q == OutMax));
    assign hs       = bus.in_valid && in_ready;
    assign cr_hs    = hs && (state_q == StCr);
    assign done     = bus.buf_mcu_done;
    assign last_mcu = (idx_q == (num_q - CNT_W'(1)));

    always_comb begin
        out_d = out_q;
        if (cr_hs && !done) begin
            out_d = out_q + 1'b1;
        end else if (!cr_hs && done && (out_q != '0)) begin
            out_d = out_q - 1'b1;
        end
    end

    always_comb begin
        err_d = err_q;
        if (done && (out_q == '0)) begin
            err_d = 1'b1;
        end
        if (start && (state_q != StIdle)) begin
            err_d = 1'b1;
        end
    end

    assign frame_done = (state_q == StDrain) && (out_d == '0);

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        num_d   = num_q;
        unique case (state_q)
            StIdle: begin
                if (start) begin
                    num_d   = num_mcu;
                    idx_d   = '0;
                    state_d = (num_mcu == '0) ? StDrain : StY0;
                end
            end
            StY0: if (hs) state_d = StY1;
            StY1: if (hs) state_d = StY2;
            StY2: if (hs) state_d = StY3;
            StY3: if (hs) state_d = StCb;
            StCb: if (hs) state_d = StCr;
            StCr: begin
                if (hs) begin
                    if (last_mcu) begin
                        state_d = StDrain;
                    end else begin
                        state_d = StY0;
                        idx_d   = idx_q + 1'b1;
                    end
                end
            end
            StDrain: if (frame_done) state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            out_q   <= '0;
            idx_q   <= '0;
            num_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            out_q   <= out_d;
            idx_q   <= idx_d;
            num_q   <= num_d;
            err_q   <= err_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            buf_valid_q <= 1'b0;
            buf_ch_q    <= 2'd0;
            buf_block_q <= '0;
        end else begin
            buf_valid_q <= hs;
            if (hs) begin
                buf_ch_q    <= slot_ch;
                buf_block_q <= bus.in_block;
            end
        end
    end

    assign bus.in_ready  = in_ready;
    assign bus.buf_valid = buf_valid_q;
    assign bus.buf_ch    = buf_ch_q;
    assign bus.buf_block = buf_block_q;

    assign busy    = (state_q != StIdle);
    assign mcu_idx = idx_q;
    assign err     = err_q;
endmodule

// File: tb/tb_mcu_sequencer.sv
// Self-checking bench for mcu_sequencer: a negedge monitor scores every buf_valid beat against
// expectations queued at each handshake; scenario tasks check control outputs inline.
`timescale 1ns/1ps
module tb_mcu_sequencer;
    localparam int unsigned MAX_OUT = 2;
    localparam int unsigned CNT_W   = 16;

    typedef logic [7:0][7:0][7:0] block_t;
    typedef struct {
        logic [1:0] ch;
        block_t     blk;
    } exp_t;

    logic             clk = 1'b0;
    logic             rst_n = 1'b1;
    logic             start = 1'b0;
    logic [CNT_W-1:0] num_mcu = '0;
    logic             busy;
    logic             frame_done;
    logic [CNT_W-1:0] mcu_idx;
    logic             err;

    int   checks = 0;
    int   failures = 0;
    exp_t sb[$];

    mcu_sequencer_if bus();

    mcu_sequencer #(
        .MAX_OUT (MAX_OUT),
        .CNT_W   (CNT_W)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .num_mcu    (num_mcu),
        .bus        (bus),
        .busy       (busy),
        .frame_done (frame_done),
        .mcu_idx    (mcu_idx),
        .err        (err)
    );

    always #5 clk = ~clk;

    // Monitor: a handshake seen before edge N must appear on buf_* right after edge N.
    initial begin
        int   slot;
        logic hs_prev;
        exp_t e;
        slot    = 0;
        hs_prev = 1'b0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                sb.delete();
                slot    = 0;
                hs_prev = 1'b0;
            end else begin
                checks++;
                if (bus.buf_valid !== hs_prev) begin
                    failures++;
                    $display("FAIL buf_valid: got %b want %b at %0t", bus.buf_valid, hs_prev, $time);
                end
                if (hs_prev && bus.buf_valid === 1'b1) begin
                    checks++;
                    if (sb.size() == 0) begin
                        failures++;
                        $display("FAIL scoreboard_empty: beat with no expectation at %0t", $time);
                    end else begin
                        e = sb.pop_front();
                        if (bus.buf_ch !== e.ch) begin
                            failures++;
                            $display("FAIL buf_ch: got %0d want %0d at %0t", bus.buf_ch, e.ch, $time);
                        end
                        checks++;
                        if (bus.buf_block !== e.blk) begin
                            failures++;
                            $display("FAIL buf_block: got %h want %h", bus.buf_block, e.blk);
                        end
                    end
                end
                hs_prev = (bus.in_valid === 1'b1) && (bus.in_ready === 1'b1);
                if (hs_prev) begin
                    e.ch  = (slot < 4) ? 2'd0 : ((slot == 4) ? 2'd1 : 2'd2);
                    e.blk = bus.in_block;
                    sb.push_back(e);
                    slot = (slot == 5) ? 0 : slot + 1;
                end
            end
        end
    end

    function automatic block_t make_block(input logic [7:0] v);
        block_t b;
        for (int r = 0; r < 8; r++) begin
            for (int c = 0; c < 8; c++) begin
                b[r][c] = (r == 0 && c == 0) ? v : 8'($urandom);
            end
        end
        return b;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_start(input logic [CNT_W-1:0] n);
        start   = 1'b1;
        num_mcu = n;
        tick();
        start   = 1'b0;
    endtask

    task automatic apply_reset();
        rst_n = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
        tick();
    endtask

    // Sends n blocks back-to-back, stalling (bounded) while in_ready is low.
    task automatic send_blocks(input int n, input logic [7:0] base);
        for (int i = 0; i < n; i++) begin
            int waited;
            waited       = 0;
            bus.in_valid = 1'b1;
            bus.in_block = make_block(base + 8'(i));
            while (bus.in_ready !== 1'b1 && waited < 50) begin
                tick();
                waited++;
            end
            if (waited >= 50) begin
                checks++;
                failures++;
                $display("FAIL send_timeout: in_ready stayed %b, block %0d", bus.in_ready, i);
                break;
            end
            tick();
        end
        bus.in_valid = 1'b0;
    endtask

    task automatic test_reset();
        #1 rst_n = 1'b0;
        #1;
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL rst_busy: got %b want 0", busy); end
        checks++; if (frame_done !== 1'b0) begin failures++; $display("FAIL rst_fd: got %b want 0", frame_done); end
        checks++; if (err !== 1'b0) begin failures++; $display("FAIL rst_err: got %b want 0", err); end
        checks++; if (mcu_idx !== '0) begin failures++; $display("FAIL rst_idx: got %0d want 0", mcu_idx); end
        checks++; if (bus.buf_valid !== 1'b0) begin failures++; $display("FAIL rst_bv: got %b want 0", bus.buf_valid); end
        checks++; if (bus.buf_ch !== 2'd0) begin failures++; $display("FAIL rst_ch: got %0d want 0", bus.buf_ch); end
        checks++; if (bus.buf_block !== '0) begin failures++; $display("FAIL rst_blk: got %h want 0", bus.buf_block); end
        checks++; if (bus.in_ready !== 1'b0) begin failures++; $display("FAIL rst_rdy: got %b want 0", bus.in_ready); end
        tick();
        tick();
        rst_n = 1'b1;
        tick();
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL idle_busy: got %b want 0", busy); end
    endtask

    task automatic test_single_mcu();
        pulse_start(16'd1);
        checks++; if (busy !== 1'b1) begin failures++; $display("FAIL sm_busy: got %b want 1", busy); end
        checks++; if (bus.in_ready !== 1'b1) begin failures++; $display("FAIL sm_rdy: got %b want 1", bus.in_ready); end
        send_blocks(6, 8'd1);
        checks++; if (bus.in_ready !== 1'b0) begin failures++; $display("FAIL sm_drain_rdy: got %b want 0", bus.in_ready); end
        tick();
        checks++; if (frame_done !== 1'b0) begin failures++; $display("FAIL sm_fd_early: got %b want 0", frame_done); end
        tick();
        bus.buf_mcu_done = 1'b1;
        #1;
        checks++; if (frame_done !== 1'b1) begin failures++; $display("FAIL sm_fd: got %b want 1", frame_done); end
        checks++; if (busy !== 1'b1) begin failures++; $display("FAIL sm_busy_fd: got %b want 1", busy); end
        tick();
        bus.buf_mcu_done = 1'b0;
        #1;
        checks++; if (frame_done !== 1'b0) begin failures++; $display("FAIL sm_fd_pulse: got %b want 0", frame_done); end
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL sm_busy_end: got %b want 0", busy); end
        checks++; if (err !== 1'b0) begin failures++; $display("FAIL sm_err: got %b want 0", err); end
    endtask

    task automatic test_backpressure();
        pulse_start(16'd4);
        send_blocks(12, 8'h10);
        bus.in_valid = 1'b1;
        bus.in_block = make_block(8'h20);
        #1;
        checks++; if (bus.in_ready !== 1'b0) begin failures++; $display("FAIL bp_rdy: got %b want 0", bus.in_ready); end
        checks++; if (mcu_idx !== 16'd2) begin failures++; $display("FAIL bp_idx: got %0d want 2", mcu_idx); end
        tick();
        tick();
        checks++; if (bus.in_ready !== 1'b0) begin failures++; $display("FAIL bp_hold: got %b want 0", bus.in_ready); end
        checks++; if (mcu_idx !== 16'd2) begin failures++; $display("FAIL bp_idx_hold: got %0d want 2", mcu_idx); end
        checks++; if (err !== 1'b0) begin failures++; $display("FAIL bp_err: got %b want 0", err); end
        bus.in_valid     = 1'b0;
        bus.buf_mcu_done = 1'b1;
        #1;
        checks++; if (bus.in_ready !== 1'b0) begin failures++; $display("FAIL bp_rdy_same: got %b want 0", bus.in_ready); end
        tick();
        bus.buf_mcu_done = 1'b0;
        #1;
        checks++; if (bus.in_ready !== 1'b1) begin failures++; $display("FAIL bp_rdy_rise: got %b want 1", bus.in_ready); end
        send_blocks(6, 8'h30);
        checks++; if (bus.in_ready !== 1'b0) begin failures++; $display("FAIL bp_rdy2: got %b want 0", bus.in_ready); end
        checks++; if (mcu_idx !== 16'd3) begin failures++; $display("FAIL bp_idx3: got %0d want 3", mcu_idx); end
        bus.buf_mcu_done = 1'b1;
        tick();
        bus.buf_mcu_done = 1'b0;
        send_blocks(6, 8'h40);
        bus.buf_mcu_done = 1'b1;
        #1;
        checks++; if (frame_done !== 1'b0) begin failures++; $display("FAIL bp_fd_early: got %b want 0", frame_done); end
        tick();
        #1;
        checks++; if (frame_done !== 1'b1) begin failures++; $display("FAIL bp_fd: got %b want 1", frame_done); end
        tick();
        bus.buf_mcu_done = 1'b0;
        #1;
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL bp_busy: got %b want 0", busy); end
        checks++; if (mcu_idx !== 16'd3) begin failures++; $display("FAIL bp_idx_idle: got %0d want 3", mcu_idx); end
        checks++; if (err !== 1'b0) begin failures++; $display("FAIL bp_err_end: got %b want 0", err); end
    endtask

    task automatic test_simultaneous();
        pulse_start(16'd2);
        send_blocks(6, 8'h50);
        send_blocks(5, 8'h60);
        bus.in_valid     = 1'b1;
        bus.in_block     = make_block(8'h65);
        bus.buf_mcu_done = 1'b1;
        #1;
        checks++; if (bus.in_ready !== 1'b1) begin failures++; $display("FAIL sim_rdy: got %b want 1", bus.in_ready); end
        tick();
        bus.in_valid     = 1'b0;
        bus.buf_mcu_done = 1'b0;
        #1;
        checks++; if (err !== 1'b0) begin failures++; $display("FAIL sim_err: got %b want 0", err); end
        checks++; if (frame_done !== 1'b0) begin failures++; $display("FAIL sim_fd0: got %b want 0", frame_done); end
        checks++; if (busy !== 1'b1) begin failures++; $display("FAIL sim_busy: got %b want 1", busy); end
        tick();
        checks++; if (frame_done !== 1'b0) begin failures++; $display("FAIL sim_fd1: got %b want 0", frame_done); end
        bus.buf_mcu_done = 1'b1;
        #1;
        checks++; if (frame_done !== 1'b1) begin failures++; $display("FAIL sim_fd: got %b want 1", frame_done); end
        tick();
        bus.buf_mcu_done = 1'b0;
        #1;
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL sim_busy_end: got %b want 0", busy); end
    endtask

    task automatic test_zero_length();
        pulse_start(16'd0);
        checks++; if (frame_done !== 1'b1) begin failures++; $display("FAIL zl_fd: got %b want 1", frame_done); end
        checks++; if (bus.in_ready !== 1'b0) begin failures++; $display("FAIL zl_rdy: got %b want 0", bus.in_ready); end
        checks++; if (mcu_idx !== '0) begin failures++; $display("FAIL zl_idx: got %0d want 0", mcu_idx); end
        tick();
        checks++; if (frame_done !== 1'b0) begin failures++; $display("FAIL zl_fd_pulse: got %b want 0", frame_done); end
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL zl_busy: got %b want 0", busy); end
    endtask

    task automatic test_errors();
        pulse_start(16'd1);
        send_blocks(2, 8'h70);
        checks++; if (err !== 1'b0) begin failures++; $display("FAIL er_pre: got %b want 0", err); end
        start   = 1'b1;
        num_mcu = 16'd7;
        tick();
        start   = 1'b0;
        checks++; if (err !== 1'b1) begin failures++; $display("FAIL er_start: got %b want 1", err); end
        checks++; if (mcu_idx !== '0) begin failures++; $display("FAIL er_idx: got %0d want 0", mcu_idx); end
        checks++; if (bus.in_ready !== 1'b1) begin failures++; $display("FAIL er_rdy: got %b want 1", bus.in_ready); end
        send_blocks(4, 8'h72);
        bus.buf_mcu_done = 1'b1;
        #1;
        checks++; if (frame_done !== 1'b1) begin failures++; $display("FAIL er_fd: got %b want 1", frame_done); end
        tick();
        bus.buf_mcu_done = 1'b0;
        apply_reset();
        checks++; if (err !== 1'b0) begin failures++; $display("FAIL er_clr: got %b want 0", err); end
        bus.buf_mcu_done = 1'b1;
        tick();
        bus.buf_mcu_done = 1'b0;
        checks++; if (err !== 1'b1) begin failures++; $display("FAIL er_done_idle: got %b want 1", err); end
        tick();
        tick();
        tick();
        checks++; if (err !== 1'b1) begin failures++; $display("FAIL er_sticky: got %b want 1", err); end
        apply_reset();
    endtask

    task automatic test_reset_mid_frame();
        pulse_start(16'd1);
        send_blocks(4, 8'h80);
        #2 rst_n = 1'b0;
        #1;
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL mr_busy: got %b want 0", busy); end
        checks++; if (frame_done !== 1'b0) begin failures++; $display("FAIL mr_fd: got %b want 0", frame_done); end
        checks++; if (bus.in_ready !== 1'b0) begin failures++; $display("FAIL mr_rdy: got %b want 0", bus.in_ready); end
        checks++; if (bus.buf_valid !== 1'b0) begin failures++; $display("FAIL mr_bv: got %b want 0", bus.buf_valid); end
        checks++; if (bus.buf_block !== '0) begin failures++; $display("FAIL mr_blk: got %h want 0", bus.buf_block); end
        checks++; if (mcu_idx !== '0) begin failures++; $display("FAIL mr_idx: got %0d want 0", mcu_idx); end
        tick();
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++; if (frame_done !== 1'b0 || busy !== 1'b0) begin
                failures++;
                $display("FAIL mr_idle: got fd=%b busy=%b want 0 0", frame_done, busy);
            end
        end
        pulse_start(16'd1);
        send_blocks(6, 8'h90);
        bus.buf_mcu_done = 1'b1;
        #1;
        checks++; if (frame_done !== 1'b1) begin failures++; $display("FAIL mr_fd_new: got %b want 1", frame_done); end
        tick();
        bus.buf_mcu_done = 1'b0;
        #1;
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL mr_busy_new: got %b want 0", busy); end
        checks++; if (err !== 1'b0) begin failures++; $display("FAIL mr_err: got %b want 0", err); end
    endtask

    initial begin
        bus.in_valid     = 1'b0;
        bus.in_block     = '0;
        bus.buf_mcu_done = 1'b0;
        test_reset();
        test_single_mcu();
        test_backpressure();
        test_simultaneous();
        test_zero_length();
        test_errors();
        test_reset_mid_frame();
        tick();
        tick();
        checks++;
        if (sb.size() != 0) begin
            failures++;
            $display("FAIL sb_leftover: got %0d pending want 0", sb.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end
endmodule

// File: doc/mcu_sequencer.md
MCU_SEQUENCER -- requirements
Module: mcu_sequencer

Parameters
REQ-001 SHALL provide MAX_OUT, default 2, the maximum number of MCUs sent to supersample_buffer_top whose buf_mcu_done has not yet been returned.
REQ-002 SHALL provide CNT_W, default 16, the width of the MCU counter.

Interface
REQ-003 clk  in  1  single clock; all state changes on the rising edge.
REQ-004 rst_n  in  1  asynchronous reset, active-low.
REQ-005 start  in  1  one-cycle pulse that begins a frame; honoured only in IDLE.
REQ-006 num_mcu  in  CNT_W  MCUs in the frame; latched when start is honoured.
REQ-007 in_valid  in  1  upstream IDCT block valid.
REQ-008 in_ready  out  1  sequencer accepts the upstream block; combinational.
REQ-009 in_block  in  [7:0][7:0] x 8  upstream 8x8 sample block; carries no channel tag.
REQ-010 buf_valid  out  1  drives supersample_buffer_top valid_in.
REQ-011 buf_ch  out  2  drives ch_in: 0=Y, 1=Cb, 2=Cr.
REQ-012 buf_block  out  [7:0][7:0] x 8  drives block_in; registered.
REQ-013 buf_mcu_done  in  1  supersample_buffer_top valid_out pulse, one per completed MCU.
REQ-014 busy  out  1  high in every state other than IDLE.
REQ-015 frame_done  out  1  one-cycle pulse at the end of a frame.
REQ-016 mcu_idx  out  CNT_W  index of the MCU currently being issued.
REQ-017 err  out  1  sticky protocol-error flag.

Function
REQ-018 SHALL implement the states IDLE, Y0, Y1, Y2, Y3, CB, CR, DRAIN, following 4:2:0 MCU order.
- IDLE -> Y0 on start when num_mcu != 0.
- IDLE -> DRAIN on start when num_mcu == 0.
REQ-019 in_ready SHALL equal (state in Y0..CR) AND NOT (state == Y0 AND outstanding == MAX_OUT).
REQ-020 A handshake (in_valid AND in_ready) SHALL advance the state one slot, following Y0->Y1->Y2->Y3->CB->CR.
REQ-021 After a handshake in CR, the next state SHALL be:
- Y0 with mcu_idx+1 when mcu_idx != num_mcu-1;
- DRAIN otherwise.
REQ-022 Each handshake SHALL produce, in the cycle after it:
- buf_valid = 1;
- buf_block = in_block;
- buf_ch = slot channel (Y0..Y3 -> 0, CB -> 1, CR -> 2).
Latency is 1 cycle.
REQ-023 buf_valid SHALL be 0 in any cycle that does not follow a handshake, and buf_block SHALL then hold its last value.
REQ-024 The outstanding counter (0..MAX_OUT) SHALL update each cycle as follows:
- +1 on a CR handshake;
- -1 on buf_mcu_done;
- unchanged when both occur in the same cycle.
REQ-025 A buf_mcu_done arriving while outstanding == 0 SHALL leave the counter at 0 and set err.
REQ-026 In DRAIN, when outstanding == 0 (already 0, or reaching 0 in the same cycle), the block SHALL pulse frame_done for one cycle and go to IDLE.
REQ-027 A start pulse outside IDLE SHALL be ignored and SHALL set err.
REQ-028 in_valid asserted while in_ready is low SHALL cause no state change and no error.
REQ-029 mcu_idx SHALL reset to 0 on each honoured start and SHALL hold its value in DRAIN and IDLE.

Reset
REQ-030 While rst_n = 0, independent of clk, the following SHALL hold:
- state = IDLE;
- buf_valid = 0, buf_ch = 0, buf_block = all zeros;
- outstanding = 0, mcu_idx = 0;
- frame_done = 0, err = 0, busy = 0.
REQ-031 Reset asserted mid-frame SHALL abandon the frame with no frame_done pulse; after reset releases, the block SHALL wait in IDLE for a new start.

Verification
REQ-032 Single MCU: start with num_mcu = 1, then 6 back-to-back valid blocks whose first element is 1..6.
- buf_valid is high for 6 consecutive cycles, each one cycle after its handshake.
- buf_ch sequence is 0,0,0,0,1,2.
- buf_mcu_done 3 cycles later -> frame_done pulses the same cycle, busy drops the next cycle.
REQ-033 Backpressure: num_mcu = 4 with MAX_OUT = 2 and buf_mcu_done withheld.
- After 12 blocks, in_ready = 0 in Y0 with mcu_idx = 2.
- One buf_mcu_done -> in_ready rises the next cycle.
REQ-034 Simultaneous events: a CR handshake and buf_mcu_done in the same cycle with outstanding = 1 -> outstanding stays 1 and err stays 0.
REQ-035 Errors:
- buf_mcu_done in IDLE -> err = 1 and remains 1 until reset.
- start while in Y2 -> ignored, state unchanged, err = 1.
REQ-036 Zero-length frame: start with num_mcu = 0 -> no in_ready, no buf_valid, frame_done 1 cycle after start.
REQ-037 Reset mid-frame: rst_n low in CB for 1 cycle -> all outputs at reset values immediately, no frame_done; a new start with num_mcu = 1 completes normally.
